// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its environment.
// master drives the PLL lock flag and run enable; slave is the sequencer.
interface pll_lock_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             run_en;
  logic             sys_rst_n;
  logic             ready;
  logic             sample_tick;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] lock_loss_cnt;

  modport master (
    output pll_locked, run_en,
    input  sys_rst_n, ready, sample_tick, state_o, lock_loss_cnt
  );

  modport slave (
    input  pll_locked, run_en,
    output sys_rst_n, ready, sample_tick, state_o, lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Synchronises the PLL locked flag, releases downstream reset after a settle window,
// strobes ADC samples in RUN. Lock-loss counter present only with LOCK_LOSS_CNT_EN.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1000,
  parameter int SAMPLE_DIV    = 100,
  parameter int CNT_W         = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  pll_lock_sequencer_if.slave  seq_if
);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_SETTLE    = 2'b01,
    ST_RUN       = 2'b10,
    ST_LOST      = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   tick_q, tick_d;
  logic                   ready_q, sys_rst_n_q, run_d;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Synchroniser, FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= ST_WAIT_LOCK;
      settle_q    <= '0;
      div_q       <= '0;
      tick_q      <= 1'b0;
      ready_q     <= 1'b0;
      sys_rst_n_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], seq_if.pll_locked};
      state_q     <= state_d;
      settle_q    <= settle_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      ready_q     <= run_d;
      sys_rst_n_q <= run_d;
    end
  end

  // Next-state, settle counter and sample divider
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    div_d    = '0;
    tick_d   = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else begin
          state_d  = ST_WAIT_LOCK;
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_d  = ST_WAIT_LOCK;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = ST_RUN;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOST:  state_d = ST_WAIT_LOCK;
      default:  state_d = ST_WAIT_LOCK;
    endcase

    // Leaving RUN or dropping run_en wins over a wrap on the same edge
    if (state_q == ST_RUN && state_d == ST_RUN && seq_if.run_en) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d  = div_q + DIV_W'(1);
        tick_d = 1'b0;
      end
    end else begin
      div_d  = '0;
      tick_d = 1'b0;
    end

    run_d = (state_d == ST_RUN);
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q, loss_d;

  // Saturating RUN->LOST event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  // Increment on lock loss from RUN unless already saturated
  always_comb begin
    loss_d = loss_q;
    if (state_q == ST_RUN && state_d == ST_LOST && loss_q != {CNT_W{1'b1}}) begin
      loss_d = loss_q + CNT_W'(1);
    end else begin
      loss_d = loss_q;
    end
  end

  assign seq_if.lock_loss_cnt = loss_q;
`else
  assign seq_if.lock_loss_cnt = CNT_W'(0);
`endif

  assign seq_if.state_o     = state_q;
  assign seq_if.ready       = ready_q;
  assign seq_if.sys_rst_n   = sys_rst_n_q;
  assign seq_if.sample_tick = tick_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench: default-parameter instance for timing/tick/reset behaviour,
// plus a short-settle instance for the lock-loss counter saturation run.
module tb_pll_lock_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   n_checks = 0;
  int   n_err    = 0;

`ifdef LOCK_LOSS_CNT_EN
  localparam int EXP_EN = 1;
`else
  localparam int EXP_EN = 0;
`endif

  always #5 clk = ~clk;

  pll_lock_sequencer_if #(.CNT_W(8)) a_if ();
  pll_lock_sequencer_if #(.CNT_W(8)) b_if ();

  pll_lock_sequencer u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (a_if)
  );

  pll_lock_sequencer #(
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (2),
    .SAMPLE_DIV    (4),
    .CNT_W         (8)
  ) u_dut_fast (
    .clk    (clk),
    .rst_n  (rst2_n),
    .seq_if (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_b_state(input logic [1:0] target);
    for (int t = 0; t < 30 && b_if.state_o != target; t++) step(1);
  endtask

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    a_if.pll_locked = 1'b1;
    a_if.run_en = 1'b0;
    b_if.pll_locked = 1'b0;
    b_if.run_en = 1'b1;
    step(3);
    chk("rst_state", 32'(a_if.state_o), 32'd0);
    chk("rst_sys_rst_n", 32'(a_if.sys_rst_n), 32'd0);
    chk("rst_ready", 32'(a_if.ready), 32'd0);
    chk("rst_tick", 32'(a_if.sample_tick), 32'd0);
    chk("rst_cnt", 32'(a_if.lock_loss_cnt), 32'd0);

    // Lock latency: SETTLE at edge 3, RUN at edge 1003
    rst_n = 1'b1;
    step(2);
    chk("t1_state_e2", 32'(a_if.state_o), 32'd0);
    step(1);
    chk("t1_state_e3", 32'(a_if.state_o), 32'd1);
    chk("t1_sysrst_e3", 32'(a_if.sys_rst_n), 32'd0);
    step(999);
    chk("t1_state_e1002", 32'(a_if.state_o), 32'd1);
    chk("t1_sysrst_e1002", 32'(a_if.sys_rst_n), 32'd0);
    chk("t1_ready_e1002", 32'(a_if.ready), 32'd0);
    step(1);
    chk("t1_state_e1003", 32'(a_if.state_o), 32'd2);
    chk("t1_sysrst_e1003", 32'(a_if.sys_rst_n), 32'd1);
    chk("t1_ready_e1003", 32'(a_if.ready), 32'd1);
    chk("t1_tick_e1003", 32'(a_if.sample_tick), 32'd0);

    // Ticks at 100, 200, 300 edges after run_en
    a_if.run_en = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step(1);
      chk("t2_tick", 32'(a_if.sample_tick), (k % 100 == 0) ? 32'd1 : 32'd0);
    end

    a_if.run_en = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      chk("t6_tick_off", 32'(a_if.sample_tick), 32'd0);
    end
    a_if.run_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      chk("t6_tick_reen", 32'(a_if.sample_tick), (k == 100) ? 32'd1 : 32'd0);
    end

    // run_en dropped exactly on the wrap edge suppresses the tick
    for (int k = 1; k <= 99; k++) begin
      step(1);
      chk("wrap_pre", 32'(a_if.sample_tick), 32'd0);
    end
    a_if.run_en = 1'b0;
    step(1);
    chk("wrap_suppr", 32'(a_if.sample_tick), 32'd0);
    a_if.run_en = 1'b1;

    // Lock loss in RUN landing on the wrap edge
    step(97);
    a_if.pll_locked = 1'b0;
    step(1);
    chk("t4_state_j98", 32'(a_if.state_o), 32'd2);
    chk("t4_ready_j98", 32'(a_if.ready), 32'd1);
    step(1);
    chk("t4_state_j99", 32'(a_if.state_o), 32'd2);
    step(1);
    chk("t4_state_lost", 32'(a_if.state_o), 32'd3);
    chk("t4_sysrst_lost", 32'(a_if.sys_rst_n), 32'd0);
    chk("t4_ready_lost", 32'(a_if.ready), 32'd0);
    chk("t4_tick_lost", 32'(a_if.sample_tick), 32'd0);
    chk("t4_cnt_lost", 32'(a_if.lock_loss_cnt), 32'(EXP_EN));
    step(1);
    chk("t4_state_after", 32'(a_if.state_o), 32'd0);

    // Lock drop 500 cycles into SETTLE, then a full re-settle
    a_if.pll_locked = 1'b1;
    step(3);
    chk("t3_settle", 32'(a_if.state_o), 32'd1);
    step(500);
    a_if.pll_locked = 1'b0;
    step(2);
    chk("t3_still_settle", 32'(a_if.state_o), 32'd1);
    step(1);
    chk("t3_back_wait", 32'(a_if.state_o), 32'd0);
    chk("t3_cnt", 32'(a_if.lock_loss_cnt), 32'(EXP_EN));
    a_if.pll_locked = 1'b1;
    step(3);
    chk("t3_resettle", 32'(a_if.state_o), 32'd1);
    step(999);
    chk("t3_e1002", 32'(a_if.state_o), 32'd1);
    chk("t3_ready_e1002", 32'(a_if.ready), 32'd0);
    step(1);
    chk("t3_e1003", 32'(a_if.state_o), 32'd2);
    chk("t3_ready_e1003", 32'(a_if.ready), 32'd1);

    // Asynchronous reset mid-RUN
    step(50);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(a_if.state_o), 32'd0);
    chk("t6_rst_sysrst", 32'(a_if.sys_rst_n), 32'd0);
    chk("t6_rst_ready", 32'(a_if.ready), 32'd0);
    chk("t6_rst_tick", 32'(a_if.sample_tick), 32'd0);
    chk("t6_rst_cnt", 32'(a_if.lock_loss_cnt), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1003);
    chk("t6_relock", 32'(a_if.state_o), 32'd2);

    // Counter saturation on the short-settle instance
    rst2_n = 1'b1;
    for (int i = 0; i < 260; i++) begin
      b_if.pll_locked = 1'b1;
      wait_b_state(2'b10);
      chk("t5_run", 32'(b_if.state_o), 32'd2);
      b_if.pll_locked = 1'b0;
      wait_b_state(2'b11);
      chk("t5_lost", 32'(b_if.state_o), 32'd3);
      chk("t5_cnt", 32'(b_if.lock_loss_cnt),
          (EXP_EN != 0) ? ((i + 1 > 255) ? 32'd255 : 32'(i + 1)) : 32'd0);
      step(1);
    end
    chk("t5_final", 32'(b_if.lock_loss_cnt), (EXP_EN != 0) ? 32'd255 : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
